// File: rtl/hour_counter.sv
// Hours stage of the digital clock: 24-hour binary timekeeping with registered
// BCD display in 24h or 12h format, a PM flag and a day-rollover pulse.
module hour_counter #(
  parameter int RESET_HOUR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_hr,
  input  logic       mode_12h,
  output logic [3:0] hr_units,
  output logic [1:0] hr_tens,
  output logic       pm,
  output logic       carry_day
);

  localparam logic [4:0] LAST_HOUR = 5'd23;
  localparam logic [4:0] RST_HOUR  = 5'(RESET_HOUR);

  logic [4:0] hour_q, hour_d;
  logic       carry_day_q, carry_day_d;
  logic [3:0] hr_units_q, hr_units_d;
  logic [1:0] hr_tens_q, hr_tens_d;
  logic       pm_q, pm_d;

  // Map an internal 0..23 hour to {tens, units} BCD for the selected format.
  function automatic logic [5:0] decode_bcd(input logic [4:0] h, input logic m12);
    logic [4:0] disp;
    logic [1:0] tens;
    logic [3:0] units;
    disp = h;
    if (m12) begin
      if (h == 5'd0)       disp = 5'd12;
      else if (h > 5'd12)  disp = h - 5'd12;
    end
    if (disp >= 5'd20) begin
      tens  = 2'd2;
      units = 4'(disp - 5'd20);
    end else if (disp >= 5'd10) begin
      tens  = 2'd1;
      units = 4'(disp - 5'd10);
    end else begin
      tens  = 2'd0;
      units = disp[3:0];
    end
    return {tens, units};
  endfunction

  // Display decodes the next-state hour so it tracks an increment with no extra lag.
  always_comb begin
    hour_d      = hour_q;
    carry_day_d = 1'b0;
    if (rst) begin
      hour_d = RST_HOUR;
    end else if (enable_hr) begin
      carry_day_d = (hour_q == LAST_HOUR);
      hour_d      = carry_day_d ? 5'd0 : hour_q + 5'd1;
    end
    {hr_tens_d, hr_units_d} = decode_bcd(hour_d, mode_12h);
    pm_d = (hour_d >= 5'd12);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hour_q      <= RST_HOUR;
      carry_day_q <= 1'b0;
    end else begin
      hour_q      <= hour_d;
      carry_day_q <= carry_day_d;
    end
    hr_units_q <= hr_units_d;
    hr_tens_q  <= hr_tens_d;
    pm_q       <= pm_d;
  end

  assign hr_units  = hr_units_q;
  assign hr_tens   = hr_tens_q;
  assign pm        = pm_q;
  assign carry_day = carry_day_q;

endmodule

// File: tb/tb_hour_counter.sv
// Self-checking bench for hour_counter: directed scenarios plus randomized
// stimulus compared against an arithmetic time-of-day model.
module tb_hour_counter;

  logic       clk;
  logic       rst;
  logic       enable_hr;
  logic       mode_12h;
  logic [3:0] hr_units, hr_units7;
  logic [1:0] hr_tens, hr_tens7;
  logic       pm, pm7;
  logic       carry_day, carry_day7;

  int n_total = 0;
  int n_pass  = 0;

  // model state and expectations
  int   m_h, m_h7, m_c, m_c7;
  logic [1:0] x_t, x_t7;
  logic [3:0] x_u, x_u7;
  logic x_pm, x_pm7, x_c, x_c7;

  hour_counter #(.RESET_HOUR(0)) dut (
    .clk(clk), .rst(rst), .enable_hr(enable_hr), .mode_12h(mode_12h),
    .hr_units(hr_units), .hr_tens(hr_tens), .pm(pm), .carry_day(carry_day)
  );

  hour_counter #(.RESET_HOUR(7)) dut7 (
    .clk(clk), .rst(rst), .enable_hr(enable_hr), .mode_12h(mode_12h),
    .hr_units(hr_units7), .hr_tens(hr_tens7), .pm(pm7), .carry_day(carry_day7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int shown(input int h, input logic m);
    if (!m) return h;
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  function automatic int advance(input int h, input logic r, input logic e, input int rh);
    if (r) return rh;
    if (e) return (h + 1) % 24;
    return h;
  endfunction

  // Drive one cycle of inputs, step the model, sample 1 time unit after the edge.
  task automatic tick(input logic r, input logic e, input logic m);
    rst = r; enable_hr = e; mode_12h = m;
    m_c  = (!r && e && m_h == 23) ? 1 : 0;
    m_c7 = (!r && e && m_h7 == 23) ? 1 : 0;
    m_h  = advance(m_h, r, e, 0);
    m_h7 = advance(m_h7, r, e, 7);
    @(posedge clk); #1;
    x_t  = 2'(shown(m_h, m) / 10);  x_u  = 4'(shown(m_h, m) % 10);
    x_pm = (m_h >= 12);             x_c  = m_c[0];
    x_t7 = 2'(shown(m_h7, m) / 10); x_u7 = 4'(shown(m_h7, m) % 10);
    x_pm7 = (m_h7 >= 12);           x_c7 = m_c7[0];
  endtask

  task automatic test_reset();
    tick(1, 0, 0); tick(1, 0, 0);
    n_total++;
    if ({hr_tens, hr_units, pm, carry_day} !== {2'd0, 4'd0, 1'b0, 1'b0})
      $display("FAIL reset_24h: got %0d%0d pm=%b c=%b want 00 pm=0 c=0", hr_tens, hr_units, pm, carry_day);
    else n_pass++;
    n_total++;
    if ({hr_tens7, hr_units7, pm7, carry_day7} !== {2'd0, 4'd7, 1'b0, 1'b0})
      $display("FAIL reset7_24h: got %0d%0d pm=%b c=%b want 07 pm=0 c=0", hr_tens7, hr_units7, pm7, carry_day7);
    else n_pass++;
    tick(1, 0, 1); tick(1, 0, 1);
    n_total++;
    if ({hr_tens, hr_units, pm, carry_day} !== {2'd1, 4'd2, 1'b0, 1'b0})
      $display("FAIL reset_12h: got %0d%0d pm=%b c=%b want 12 pm=0 c=0", hr_tens, hr_units, pm, carry_day);
    else n_pass++;
  endtask

  task automatic test_full_day(input logic m);
    int carries;
    carries = 0;
    tick(1, 0, m);
    for (int i = 1; i <= 24; i++) begin
      tick(0, 1, m);
      n_total++;
      if ({hr_tens, hr_units, pm, carry_day} !== {x_t, x_u, x_pm, x_c} || carry_day !== (i == 24))
        $display("FAIL full_day m=%b pulse %0d: got %0d%0d pm=%b c=%b want %0d%0d pm=%b c=%b",
                 m, i, hr_tens, hr_units, pm, carry_day, x_t, x_u, x_pm, (i == 24));
      else n_pass++;
      if (carry_day === 1'b1) carries++;
      for (int g = 0; g < 2; g++) begin
        tick(0, 0, m);
        if (carry_day === 1'b1) carries++;
      end
      n_total++;
      if ({hr_tens, hr_units, pm} !== {x_t, x_u, x_pm})
        $display("FAIL full_day_hold m=%b pulse %0d: got %0d%0d pm=%b want %0d%0d pm=%b",
                 m, i, hr_tens, hr_units, pm, x_t, x_u, x_pm);
      else n_pass++;
    end
    n_total++;
    if (carries != 1 || {hr_tens, hr_units, pm} !== {(m ? 2'd1 : 2'd0), (m ? 4'd2 : 4'd0), 1'b0})
      $display("FAIL full_day_end m=%b: carries=%0d disp=%0d%0d pm=%b want 1 carry, disp %s pm=0",
               m, carries, hr_tens, hr_units, pm, m ? "12" : "00");
    else n_pass++;
  endtask

  task automatic test_continuous();
    int carries;
    carries = 0;
    tick(1, 0, 0);
    for (int i = 1; i <= 30; i++) begin
      tick(0, 1, 0);
      if (carry_day === 1'b1) carries++;
      n_total++;
      if ({hr_tens, hr_units, pm, carry_day} !== {x_t, x_u, x_pm, x_c} || carry_day !== (i == 24))
        $display("FAIL continuous cycle %0d: got %0d%0d pm=%b c=%b want %0d%0d pm=%b c=%b",
                 i, hr_tens, hr_units, pm, carry_day, x_t, x_u, x_pm, (i == 24));
      else n_pass++;
    end
    n_total++;
    if (carries != 1 || {hr_tens, hr_units} !== {2'd0, 4'd6})
      $display("FAIL continuous_end: carries=%0d disp=%0d%0d want 1 carry, 06", carries, hr_tens, hr_units);
    else n_pass++;
  endtask

  task automatic test_mode_toggle();
    tick(1, 0, 0);
    for (int i = 0; i < 15; i++) tick(0, 1, 0);
    n_total++;
    if ({hr_tens, hr_units, pm} !== {2'd1, 4'd5, 1'b1})
      $display("FAIL toggle_at15: got %0d%0d pm=%b want 15 pm=1", hr_tens, hr_units, pm);
    else n_pass++;
    tick(0, 0, 1);
    n_total++;
    if ({hr_tens, hr_units, pm} !== {2'd0, 4'd3, 1'b1})
      $display("FAIL toggle_to_12h: got %0d%0d pm=%b want 03 pm=1", hr_tens, hr_units, pm);
    else n_pass++;
    tick(0, 0, 0);
    n_total++;
    if ({hr_tens, hr_units, pm} !== {2'd1, 4'd5, 1'b1})
      $display("FAIL toggle_to_24h: got %0d%0d pm=%b want 15 pm=1", hr_tens, hr_units, pm);
    else n_pass++;
    tick(0, 1, 1);
    n_total++;
    if ({hr_tens, hr_units, pm, carry_day} !== {2'd0, 4'd4, 1'b1, 1'b0})
      $display("FAIL toggle_with_enable: got %0d%0d pm=%b c=%b want 04 pm=1 c=0", hr_tens, hr_units, pm, carry_day);
    else n_pass++;
  endtask

  task automatic test_reset_during_wrap();
    tick(1, 0, 0);
    for (int i = 0; i < 23; i++) tick(0, 1, 0);
    n_total++;
    if ({hr_tens, hr_units, pm} !== {2'd2, 4'd3, 1'b1})
      $display("FAIL wrap_at23: got %0d%0d pm=%b want 23 pm=1", hr_tens, hr_units, pm);
    else n_pass++;
    tick(1, 1, 0);
    n_total++;
    if ({hr_tens, hr_units, pm, carry_day} !== {2'd0, 4'd0, 1'b0, 1'b0})
      $display("FAIL wrap_reset: got %0d%0d pm=%b c=%b want 00 pm=0 c=0", hr_tens, hr_units, pm, carry_day);
    else n_pass++;
    n_total++;
    if ({hr_tens7, hr_units7, carry_day7} !== {2'd0, 4'd7, 1'b0})
      $display("FAIL wrap_reset7: got %0d%0d c=%b want 07 c=0", hr_tens7, hr_units7, carry_day7);
    else n_pass++;
    tick(0, 0, 0);
    n_total++;
    if ({hr_tens, hr_units, carry_day} !== {2'd0, 4'd0, 1'b0})
      $display("FAIL wrap_after: got %0d%0d c=%b want 00 c=0", hr_tens, hr_units, carry_day);
    else n_pass++;
  endtask

  task automatic test_random();
    logic m, e, r;
    m = 1'b0;
    tick(1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) m = ~m;
      tick(r, e, m);
      n_total++;
      if ({hr_tens, hr_units, pm, carry_day} !== {x_t, x_u, x_pm, x_c} ||
          {hr_tens7, hr_units7, pm7, carry_day7} !== {x_t7, x_u7, x_pm7, x_c7})
        $display("FAIL random cycle %0d r=%b e=%b m=%b: got %0d%0d/%b/%b and %0d%0d/%b/%b want %0d%0d/%b/%b and %0d%0d/%b/%b",
                 i, r, e, m, hr_tens, hr_units, pm, carry_day, hr_tens7, hr_units7, pm7, carry_day7,
                 x_t, x_u, x_pm, x_c, x_t7, x_u7, x_pm7, x_c7);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; enable_hr = 1'b0; mode_12h = 1'b0;
    m_h = 0; m_h7 = 7; m_c = 0; m_c7 = 0;
    test_reset();
    test_full_day(1'b0);
    test_full_day(1'b1);
    test_continuous();
    test_mode_toggle();
    test_reset_during_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
